// File: rtl/insn_fetch.sv
// insn_fetch: owns the PC, issues 1-cycle-latency imem reads and queues up to 2 insns for decode.
// Optional FETCH_PERF_EN adds stall_cnt_o, a count of cycles with no valid instruction.
module insn_fetch #(
   parameter int LEN_INSN = 32,
   parameter int LEN_PC = 16,
   parameter logic [LEN_PC-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_o,
   output logic [LEN_PC-1:0]   imem_addr_o,
   input  logic [LEN_INSN-1:0] imem_data_i,
   input  logic                redirect_i,
   input  logic [LEN_PC-1:0]   redirect_pc_i,
   output logic                insn_valid_o,
   input  logic                insn_ready_i,
   output logic [LEN_INSN-1:0] insn_o,
   output logic [LEN_PC-1:0]   insn_pc_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]         stall_cnt_o
`endif
);
   logic [LEN_PC-1:0] pc, inflight_pc, h_pc, s_pc;
   logic [LEN_INSN-1:0] h_insn, s_insn;
   logic inflight, kill, pop, push;
   logic [1:0] cnt, credit;
   always_comb begin
      insn_valid_o = !rst && cnt != 2'd0;
      pop = insn_valid_o && insn_ready_i && !redirect_i;
      credit = cnt + 2'(inflight);
      imem_req_o = !rst && !redirect_i && (credit < 2'd2 || (credit == 2'd2 && pop));
      push = inflight && !kill && !redirect_i;
      imem_addr_o = pc;
      insn_o = h_insn;
      insn_pc_o = h_pc;
   end
   // credit never exceeds 2, so a push always lands with cnt <= 1
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
         inflight <= 1'b0;
         inflight_pc <= '0;
         kill <= 1'b0;
         cnt <= 2'd0;
         h_insn <= '0;
         h_pc <= '0;
         s_insn <= '0;
         s_pc <= '0;
      end else begin
         inflight <= imem_req_o;
         kill <= redirect_i;
         if (imem_req_o) begin
            pc <= pc + LEN_PC'(1);
            inflight_pc <= pc;
         end
         if (redirect_i) begin
            pc <= redirect_pc_i;
            cnt <= 2'd0;
         end else begin
            if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) begin
               h_insn <= imem_data_i;
               h_pc <= inflight_pc;
            end else if (pop) begin
               h_insn <= s_insn;
               h_pc <= s_pc;
            end
            if (push && cnt == 2'd1 && !pop) begin
               s_insn <= imem_data_i;
               s_pc <= inflight_pc;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
         end
      end
   end
`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) stall_cnt_o <= 32'd0;
      else if (!insn_valid_o) stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif
endmodule

// File: tb/tb_insn_fetch.sv
// tb_insn_fetch: queue-based reference model of fetch credits, latency and redirect flushing.
module tb_insn_fetch;
   logic clk = 1'b0, rst = 1'b1, insn_ready = 1'b0, redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0, imem_addr, insn_pc, w_addr, w_pc;
   logic [31:0] imem_data, insn, w_data, w_insn;
   logic imem_req, insn_valid, w_req, w_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt, w_stall;
`endif
   int n_cmp = 0, n_bad = 0;

   insn_fetch dut (
      .clk(clk), .rst(rst), .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc), .insn_valid_o(insn_valid),
      .insn_ready_i(insn_ready), .insn_o(insn), .insn_pc_o(insn_pc)
`ifdef FETCH_PERF_EN
      , .stall_cnt_o(stall_cnt)
`endif
   );
   insn_fetch #(.RESET_PC(16'hFFFE)) dut_w (
      .clk(clk), .rst(rst), .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_data_i(w_data),
      .redirect_i(1'b0), .redirect_pc_i(16'h0), .insn_valid_o(w_valid),
      .insn_ready_i(1'b1), .insn_o(w_insn), .insn_pc_o(w_pc)
`ifdef FETCH_PERF_EN
      , .stall_cnt_o(w_stall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [15:0] a);
      return {~a, a};
   endfunction

   always @(posedge clk) begin
      imem_data <= memf(imem_addr);
      w_data <= memf(w_addr);
   end

   // model: queue of fetched-not-consumed PCs, each usable 2 cycles after its request
   logic [15:0] q_pc[$];
   int q_t[$];
   logic [15:0] m_pc = 16'h0, m_head = 16'h0, p_tgt = 16'h0;
   logic m_valid = 1'b0, m_pop = 1'b0, m_req = 1'b0;
   logic p_rst = 1'b1, p_rd = 1'b0;
   int now = 0;
   int unsigned m_stall = 0;

   task automatic cycle(input logic r, input logic rdy, input logic rd, input logic [15:0] tgt);
      @(posedge clk);
      if (p_rst) m_stall = 0;
      else if (!m_valid) m_stall++;
      if (p_rst || p_rd) begin
         q_pc.delete();
         q_t.delete();
         m_pc = p_rst ? 16'h0 : p_tgt;
      end else begin
         if (m_pop) begin
            void'(q_pc.pop_front());
            void'(q_t.pop_front());
         end
         if (m_req) begin
            q_pc.push_back(m_pc);
            q_t.push_back(now + 2);
            m_pc = m_pc + 16'd1;
         end
      end
      now++;
      #1;
      rst = r;
      insn_ready = rdy;
      redirect = rd;
      redirect_pc = tgt;
      p_rst = r;
      p_rd = rd;
      p_tgt = tgt;
      m_valid = !r && q_pc.size() > 0 && q_t[0] <= now;
      m_head = m_valid ? q_pc[0] : 16'h0;
      m_pop = m_valid && rdy && !rd;
      m_req = !r && !rd && (q_pc.size() < 2 || (q_pc.size() == 2 && m_pop));
      @(negedge clk);
   endtask

   task automatic test_reset;
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      n_cmp += 5;
      if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", imem_req); end
      if (insn_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", insn_valid); end
      if (imem_addr !== 16'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0000", imem_addr); end
      if (insn !== 32'h0) begin n_bad++; $display("FAIL reset_insn got %h want 0", insn); end
      if (insn_pc !== 16'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0000", insn_pc); end
`ifdef FETCH_PERF_EN
      n_cmp++;
      if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
`endif
   endtask

   task automatic test_stream;
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      for (int c = 0; c < 16; c++) begin
         cycle(1'b0, 1'b1, 1'b0, 16'h0);
         n_cmp++;
         if (insn_valid !== m_valid) begin n_bad++; $display("FAIL stream_valid c=%0d got %b want %b", c, insn_valid, m_valid); end
         if (c >= 2) begin
            n_cmp += 2;
            if (insn_pc !== 16'(c - 2)) begin n_bad++; $display("FAIL stream_pc c=%0d got %h want %h", c, insn_pc, 16'(c - 2)); end
            if (insn !== memf(16'(c - 2))) begin n_bad++; $display("FAIL stream_insn c=%0d got %h want %h", c, insn, memf(16'(c - 2))); end
         end
      end
   endtask

   task automatic test_backpressure;
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      for (int c = 0; c < 16; c++) begin
         cycle(1'b0, !(c >= 2 && c < 7), 1'b0, 16'h0);
         n_cmp += 2;
         if (imem_req !== m_req) begin n_bad++; $display("FAIL bp_req c=%0d got %b want %b", c, imem_req, m_req); end
         if (insn_valid !== m_valid) begin n_bad++; $display("FAIL bp_valid c=%0d got %b want %b", c, insn_valid, m_valid); end
         if (m_valid) begin
            n_cmp++;
            if (insn_pc !== m_head) begin n_bad++; $display("FAIL bp_pc c=%0d got %h want %h", c, insn_pc, m_head); end
         end
      end
   endtask

   task automatic test_redirect(input int low_cycles);
      int lat;
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
      for (int c = 0; c < low_cycles; c++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
      cycle(1'b0, 1'b0, 1'b1, 16'h0040);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 16'h0);
         n_cmp++;
         if (insn_valid !== m_valid) begin n_bad++; $display("FAIL redir_valid k=%0d got %b want %b", k, insn_valid, m_valid); end
         if (insn_valid && lat == 0) begin
            lat = k;
            n_cmp++;
            if (insn_pc !== 16'h0040) begin n_bad++; $display("FAIL redir_first_pc got %h want 0040", insn_pc); end
         end
         if (m_valid) begin
            n_cmp++;
            if (insn_pc !== m_head || insn !== memf(m_head)) begin n_bad++; $display("FAIL redir_head k=%0d got %h/%h want %h/%h", k, insn_pc, insn, m_head, memf(m_head)); end
         end
      end
      n_cmp++;
      if (lat != 3) begin n_bad++; $display("FAIL redir_latency got %0d want 3", lat); end
   endtask

   task automatic test_redirect_pop;
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
      cycle(1'b0, 1'b1, 1'b1, 16'h1234);
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 16'h0);
         n_cmp++;
         if (insn_valid !== m_valid) begin n_bad++; $display("FAIL rpop_valid k=%0d got %b want %b", k, insn_valid, m_valid); end
         if (k >= 3) begin
            n_cmp++;
            if (insn_pc !== 16'(16'h1234 + k - 3)) begin n_bad++; $display("FAIL rpop_pc k=%0d got %h want %h", k, insn_pc, 16'(16'h1234 + k - 3)); end
         end
      end
   endtask

   task automatic test_random;
      logic r, rdy, rd;
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      for (int c = 0; c < 500; c++) begin
         r = $urandom_range(99) == 0;
         rdy = $urandom_range(99) < 65;
         rd = $urandom_range(99) < 6;
         cycle(r, rdy, rd, 16'($urandom));
         n_cmp += 2;
         if (imem_req !== m_req) begin n_bad++; $display("FAIL rnd_req c=%0d got %b want %b", c, imem_req, m_req); end
         if (insn_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got %b want %b", c, insn_valid, m_valid); end
         if (m_req) begin
            n_cmp++;
            if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr c=%0d got %h want %h", c, imem_addr, m_pc); end
         end
         if (m_valid) begin
            n_cmp++;
            if (insn_pc !== m_head || insn !== memf(m_head)) begin n_bad++; $display("FAIL rnd_head c=%0d got %h/%h want %h/%h", c, insn_pc, insn, m_head, memf(m_head)); end
         end
`ifdef FETCH_PERF_EN
         n_cmp++;
         if (stall_cnt !== m_stall) begin n_bad++; $display("FAIL rnd_stall c=%0d got %0d want %0d", c, stall_cnt, m_stall); end
`endif
      end
   endtask

   task automatic test_wrap;
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      for (int c = 0; c < 5; c++) begin
         cycle(1'b0, 1'b1, 1'b0, 16'h0);
         if (c == 0) begin
            n_cmp++;
            if (w_req !== 1'b1 || w_addr !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_req got %b/%h want 1/fffe", w_req, w_addr); end
         end
         if (c >= 2) begin
            n_cmp++;
            if (w_valid !== 1'b1 || w_pc !== 16'(16'hFFFE + c - 2) || w_insn !== memf(16'(16'hFFFE + c - 2)))
               begin n_bad++; $display("FAIL wrap_seq c=%0d got %b/%h/%h want 1/%h", c, w_valid, w_pc, w_insn, 16'(16'hFFFE + c - 2)); end
         end
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf;
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
      cycle(1'b0, 1'b1, 1'b1, 16'h0080);
      for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
      n_cmp++;
      if (stall_cnt !== m_stall) begin n_bad++; $display("FAIL perf_stall got %0d want %0d", stall_cnt, m_stall); end
   endtask
`endif

   initial begin
      test_reset;
      test_stream;
      test_backpressure;
      test_redirect(0);
      test_redirect(3);
      test_redirect_pop;
      test_wrap;
`ifdef FETCH_PERF_EN
      test_perf;
`endif
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
